enc_period_quad_sync: RTL and testbench

- Fully synchronous, parametrised successor to the existing quadrature encoder period measurement.
- Measures the encoder full-cycle period by counting clk_fast cycles between successive same-type edges (A rise, A fall, B rise, B fall).
- Reports the larger of the most recent latched period and the free-running count toward the next expected edge.
- Sits between the encoder input pins and the velocity register read by the host interface. It adds input synchronisation, saturation, direction-change tainting and illegal-transition detection.

---
 rtl/enc_period_pkg.sv | 27 ++
 rtl/enc_period_quad_sync_timer.sv | 50 +++++
 rtl/enc_period_quad_sync.sv | 122 ++++++++++++
 tb/tb_enc_period_quad_sync.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_period_pkg.sv
// Shared types and helpers for the quadrature encoder period measurement.
// Edge codes, the expected-next-edge table and the default counter width.
package enc_period_pkg;

  localparam int CNT_W_DEFAULT = 22;

  typedef enum logic [1:0] {
    A_UP = 2'd0,
    A_DN = 2'd1,
    B_UP = 2'd2,
    B_DN = 2'd3
  } edge_t;

  // dir=0 cycles A_UP->B_UP->A_DN->B_DN; dir=1 walks the same ring backwards
  function automatic edge_t next_edge(input edge_t last, input logic dir);
    edge_t nxt;
    case (last)
      A_UP:    nxt = dir ? B_DN : B_UP;
      B_UP:    nxt = dir ? A_UP : A_DN;
      A_DN:    nxt = dir ? B_UP : B_DN;
      B_DN:    nxt = dir ? A_DN : A_UP;
      default: nxt = A_UP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/enc_period_quad_sync_timer.sv
// Per-edge period timer: saturating counter, latch on edge, direction-change taint.
// The counter never wraps; it sticks at all-ones until its own edge clears it.
module enc_edge_timer
  import enc_period_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_fast,
  input  logic             reset,
  input  logic             edge_pulse,
  input  logic             dir_chg,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_ovf,
  output logic             taint,
  output logic [CNT_W-1:0] lat,
  output logic             lat_ovf,
  output logic             lat_dc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign cnt_ovf = (cnt == CNT_MAX);

  // An own-edge pulse outranks a direction change; the latch still records the taint
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      taint   <= 1'b0;
      lat     <= '0;
      lat_ovf <= 1'b0;
      lat_dc  <= 1'b0;
    end else if (edge_pulse) begin
      lat     <= cnt;
      lat_ovf <= cnt_ovf;
      lat_dc  <= taint | dir_chg;
      cnt     <= '0;
      taint   <= 1'b0;
    end else if (dir_chg) begin
      cnt     <= CNT_MAX;
      taint   <= 1'b1;
    end else begin
      cnt     <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/enc_period_quad_sync.sv
// Quadrature encoder full-cycle period measurement on clk_fast.
// Synchronises A/B, detects edges, times each edge type and reports the larger period.
module enc_period_quad_sync
  import enc_period_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_fast,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             dir,
  output logic [CNT_W-1:0] period_o,
  output logic             src_o,
  output logic [1:0]       edge_o,
  output logic             ovf_o,
  output logic             dir_chg_o,
  output logic             edge_stb_o,
  output logic             err_o
);

  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic                   a_d, b_d;
  logic [3:0]             pulse_p1;
  logic                   dir_r;
  logic                   dir_chg;

  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] lat [4];
  logic [3:0]       cnt_ovf, taint, lat_ovf, lat_dc;

  edge_t last_e;
  edge_t nxt;
  logic  cnt_wins;
  logic  multi_edge;

  // Stage p0: synchroniser chain and delayed copy; p1: registered edge pulses
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      a_sync   <= '0;
      b_sync   <= '0;
      a_d      <= 1'b0;
      b_d      <= 1'b0;
      pulse_p1 <= '0;
      dir_r    <= 1'b0;
    end else begin
      a_sync         <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync         <= {b_sync[SYNC_STAGES-2:0], b};
      a_d            <= a_sync[SYNC_STAGES-1];
      b_d            <= b_sync[SYNC_STAGES-1];
      pulse_p1[A_UP] <= a_sync[SYNC_STAGES-1] & ~a_d;
      pulse_p1[A_DN] <= ~a_sync[SYNC_STAGES-1] & a_d;
      pulse_p1[B_UP] <= b_sync[SYNC_STAGES-1] & ~b_d;
      pulse_p1[B_DN] <= ~b_sync[SYNC_STAGES-1] & b_d;
      dir_r          <= dir;
    end
  end

  assign dir_chg    = dir ^ dir_r;
  assign multi_edge = (pulse_p1 & (pulse_p1 - 4'd1)) != 4'd0;

  for (genvar e = 0; e < 4; e++) begin : g_timer
    enc_edge_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_fast   (clk_fast),
      .reset      (reset),
      .edge_pulse (pulse_p1[e]),
      .dir_chg    (dir_chg),
      .cnt        (cnt[e]),
      .cnt_ovf    (cnt_ovf[e]),
      .taint      (taint[e]),
      .lat        (lat[e]),
      .lat_ovf    (lat_ovf[e]),
      .lat_dc     (lat_dc[e])
    );
  end

  // Simultaneous pulses resolve A_UP > B_UP > A_DN > B_DN and flag an error
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      last_e <= A_UP;
      err_o  <= 1'b0;
    end else begin
      if (pulse_p1[A_UP])      last_e <= A_UP;
      else if (pulse_p1[B_UP]) last_e <= B_UP;
      else if (pulse_p1[A_DN]) last_e <= A_DN;
      else if (pulse_p1[B_DN]) last_e <= B_DN;
      if (multi_edge) err_o <= 1'b1;
    end
  end

  assign nxt      = next_edge(last_e, dir);
  assign cnt_wins = cnt[nxt] >= lat[last_e];

  // Stage p2: registered output mux, all fields update together
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      period_o   <= '0;
      src_o      <= 1'b0;
      edge_o     <= 2'd0;
      ovf_o      <= 1'b0;
      dir_chg_o  <= 1'b0;
      edge_stb_o <= 1'b0;
    end else begin
      if (cnt_wins) begin
        period_o  <= cnt[nxt];
        src_o     <= 1'b0;
        edge_o    <= nxt;
        ovf_o     <= cnt_ovf[nxt];
        dir_chg_o <= taint[nxt];
      end else begin
        period_o  <= lat[last_e];
        src_o     <= 1'b1;
        edge_o    <= last_e;
        ovf_o     <= lat_ovf[last_e];
        dir_chg_o <= lat_dc[last_e];
      end
      edge_stb_o <= |pulse_p1;
    end
  end

endmodule

// File: tb/tb_enc_period_quad_sync.sv
// Self-checking bench for enc_period_quad_sync against a timestamp-based reference model.
module tb_enc_period_quad_sync;

  localparam int CNT_W       = 9;
  localparam int SYNC_STAGES = 2;
  localparam int MAXV        = (1 << CNT_W) - 1;
  localparam int VW          = CNT_W + 7;
  localparam int E_A_UP = 0, E_A_DN = 1, E_B_UP = 2, E_B_DN = 3;

  logic             clk_fast = 1'b0;
  logic             reset, a, b, dir;
  logic [CNT_W-1:0] period_o;
  logic             src_o, ovf_o, dir_chg_o, edge_stb_o, err_o;
  logic [1:0]       edge_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_fast = ~clk_fast;

  enc_period_quad_sync #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_fast   (clk_fast),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .dir        (dir),
    .period_o   (period_o),
    .src_o      (src_o),
    .edge_o     (edge_o),
    .ovf_o      (ovf_o),
    .dir_chg_o  (dir_chg_o),
    .edge_stb_o (edge_stb_o),
    .err_o      (err_o)
  );

  // Reference model: each timer is described by the cycle of its last clear and a taint flag
  int          m_n;
  int          m_clr [4];
  bit          m_taint [4];
  int          m_lat [4];
  bit          m_lat_ovf [4];
  bit          m_lat_dc [4];
  int          m_last;
  bit          m_err, m_dir, m_pa, m_pb;
  bit [3:0]    m_sched [8];
  logic [VW-1:0] exp_vec;
  int          phase;

  function automatic int ring_pos(input int e);
    case (e)
      E_A_UP:  return 0;
      E_B_UP:  return 1;
      E_A_DN:  return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int ring_edge(input int p);
    case (p)
      0:       return E_A_UP;
      1:       return E_B_UP;
      2:       return E_A_DN;
      default: return E_B_DN;
    endcase
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {period_o, src_o, edge_o, ovf_o, dir_chg_o, edge_stb_o, err_o};
  endfunction

  task automatic model_reset();
    m_n = 0; m_last = E_A_UP; m_err = 0; m_dir = 0; m_pa = 0; m_pb = 0;
    for (int e = 0; e < 4; e++) begin
      m_clr[e] = 0; m_taint[e] = 0; m_lat[e] = 0; m_lat_ovf[e] = 0; m_lat_dc[e] = 0;
    end
    for (int i = 0; i < 8; i++) m_sched[i] = '0;
    exp_vec = '0;
  endtask

  task automatic model_step();
    bit [3:0] det, pm;
    bit dc, src, ovf, tdc;
    int cv [4];
    int nx, val, sel, age;
    if (reset !== 1'b1) return;
    det = '0;
    if (a && !m_pa) det[E_A_UP] = 1;
    if (!a && m_pa) det[E_A_DN] = 1;
    if (b && !m_pb) det[E_B_UP] = 1;
    if (!b && m_pb) det[E_B_DN] = 1;
    m_pa = a; m_pb = b;
    // a pin change seen at this edge is acted on SYNC_STAGES+1 edges later
    m_sched[(m_n + 1 + SYNC_STAGES + 1) % 8] |= det;
    pm = m_sched[(m_n + 1) % 8];
    m_sched[(m_n + 1) % 8] = '0;
    dc = (dir != m_dir);
    m_dir = dir;
    for (int e = 0; e < 4; e++) begin
      age = m_n - m_clr[e];
      cv[e] = m_taint[e] ? MAXV : (age > MAXV ? MAXV : age);
    end
    nx = ring_edge(dir ? (ring_pos(m_last) + 3) % 4 : (ring_pos(m_last) + 1) % 4);
    if (cv[nx] >= m_lat[m_last]) begin
      val = cv[nx]; src = 0; sel = nx; ovf = (cv[nx] == MAXV); tdc = m_taint[nx];
    end else begin
      val = m_lat[m_last]; src = 1; sel = m_last; ovf = m_lat_ovf[m_last]; tdc = m_lat_dc[m_last];
    end
    for (int e = 0; e < 4; e++) begin
      if (pm[e]) begin
        m_lat[e] = cv[e]; m_lat_ovf[e] = (cv[e] == MAXV); m_lat_dc[e] = m_taint[e] | dc;
        m_clr[e] = m_n + 1; m_taint[e] = 0;
      end else if (dc) begin
        m_taint[e] = 1;
      end
    end
    if (pm[E_A_UP]) m_last = E_A_UP;
    else if (pm[E_B_UP]) m_last = E_B_UP;
    else if (pm[E_A_DN]) m_last = E_A_DN;
    else if (pm[E_B_DN]) m_last = E_B_DN;
    if ($countones(pm) > 1) m_err = 1;
    m_n = m_n + 1;
    exp_vec = {CNT_W'(val), src, 2'(sel), ovf, tdc, (pm != 0), m_err};
  endtask

  task automatic cyc();
    @(posedge clk_fast);
    model_step();
    @(negedge clk_fast);
  endtask

  task automatic step_pins(input bit fwd);
    phase = fwd ? (phase + 1) % 4 : (phase + 3) % 4;
    a = (phase == 1 || phase == 2);
    b = (phase == 2 || phase == 3);
  endtask

  task automatic test_reset();
    logic [CNT_W-1:0] prev;
    reset = 1'b0; a = 0; b = 0; dir = 0; phase = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      a = i[0]; b = ~i[0];
      cyc();
      checks++;
      if (dut_vec() !== '0) begin
        errors++; $display("FAIL reset_hold got %h exp 0", dut_vec());
      end
    end
    a = 0; b = 0;
    reset = 1'b1;
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++; $display("FAIL reset_idle got %h exp %h", dut_vec(), exp_vec);
      end
      checks++;
      if (src_o !== 1'b0 || edge_o !== 2'(E_B_UP) || (i > 0 && period_o !== prev + 1'b1)) begin
        errors++; $display("FAIL reset_count period %0d prev %0d src %b edge %0d", period_o, prev, src_o, edge_o);
      end
      prev = period_o;
    end
  endtask

  task automatic test_forward();
    int first_k;
    dir = 0;
    for (int s = 0; s < 12; s++) begin
      step_pins(1);
      first_k = -1;
      for (int k = 1; k <= 100; k++) begin
        cyc();
        checks++;
        if (dut_vec() !== exp_vec) begin
          errors++; $display("FAIL fwd_model step %0d got %h exp %h", s, dut_vec(), exp_vec);
        end
        if (edge_stb_o === 1'b1 && first_k < 0) first_k = k;
        if (s >= 8 && k == 50) begin
          checks++;
          if (src_o !== 1'b1 || period_o < 399 || period_o > 401) begin
            errors++; $display("FAIL fwd_period got %0d src %b exp 400+-1 src 1", period_o, src_o);
          end
        end
      end
      checks++;
      if (first_k != SYNC_STAGES + 2) begin
        errors++; $display("FAIL fwd_stb_latency got %0d exp %0d", first_k, SYNC_STAGES + 2);
      end
    end
  endtask

  task automatic test_decel();
    logic [CNT_W-1:0] prev;
    logic prev_src;
    bit saw_cnt;
    prev = period_o; prev_src = src_o; saw_cnt = 0;
    for (int k = 0; k < 700; k++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++; $display("FAIL decel_model got %h exp %h", dut_vec(), exp_vec);
      end
      if (src_o === 1'b0 && prev_src === 1'b0 && int'(prev) < MAXV) begin
        saw_cnt = 1;
        checks++;
        if (period_o !== prev + 1'b1) begin
          errors++; $display("FAIL decel_rise got %0d exp %0d", period_o, prev + 1'b1);
        end
      end
      prev = period_o; prev_src = src_o;
    end
    checks++;
    if (!saw_cnt || int'(period_o) != MAXV || ovf_o !== 1'b1) begin
      errors++; $display("FAIL decel_sat got %0d ovf %b rose %0d exp %0d ovf 1", period_o, ovf_o, saw_cnt, MAXV);
    end
  endtask

  task automatic test_saturation();
    for (int s = 0; s < 5; s++) begin
      step_pins(1);
      for (int k = 1; k <= 100; k++) begin
        cyc();
        checks++;
        if (dut_vec() !== exp_vec) begin
          errors++; $display("FAIL sat_model step %0d got %h exp %h", s, dut_vec(), exp_vec);
        end
        if (k == 50 && s == 0) begin
          checks++;
          if (int'(period_o) != MAXV || ovf_o !== 1'b1) begin
            errors++; $display("FAIL sat_latch got %0d ovf %b exp %0d ovf 1", period_o, ovf_o, MAXV);
          end
        end
        if (k == 50 && s == 4) begin
          checks++;
          if (ovf_o !== 1'b0 || period_o !== CNT_W'(399)) begin
            errors++; $display("FAIL sat_clear got %0d ovf %b exp 399 ovf 0", period_o, ovf_o);
          end
        end
      end
    end
  endtask

  task automatic test_reversal();
    for (int s = 0; s < 8; s++) begin
      step_pins(1);
      repeat (100) begin
        cyc();
        checks++;
        if (dut_vec() !== exp_vec) begin
          errors++; $display("FAIL rev_pre got %h exp %h", dut_vec(), exp_vec);
        end
      end
    end
    dir = 1;
    cyc();
    cyc();
    checks++;
    if (int'(period_o) != MAXV || dir_chg_o !== 1'b1 || src_o !== 1'b0) begin
      errors++; $display("FAIL rev_force got %0d dc %b src %b exp %0d dc 1 src 0", period_o, dir_chg_o, src_o, MAXV);
    end
    for (int s = 0; s < 8; s++) begin
      step_pins(0);
      for (int k = 1; k <= 100; k++) begin
        cyc();
        checks++;
        if (dut_vec() !== exp_vec) begin
          errors++; $display("FAIL rev_model step %0d got %h exp %h", s, dut_vec(), exp_vec);
        end
        if (k == 50 && s == 3) begin
          checks++;
          if (dir_chg_o !== 1'b1 || src_o !== 1'b1) begin
            errors++; $display("FAIL rev_first_latch dc %b src %b exp dc 1 src 1", dir_chg_o, src_o);
          end
        end
        if (k == 50 && s == 7) begin
          checks++;
          if (dir_chg_o !== 1'b0 || src_o !== 1'b1) begin
            errors++; $display("FAIL rev_second_latch dc %b src %b exp dc 0 src 1", dir_chg_o, src_o);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int gap;
    for (int s = 0; s < 50; s++) begin
      if ($urandom_range(7, 0) == 0) dir = ~dir;
      step_pins(dir == 1'b0);
      gap = $urandom_range(150, 5);
      repeat (gap) begin
        cyc();
        checks++;
        if (dut_vec() !== exp_vec) begin
          errors++; $display("FAIL rand_model step %0d got %h exp %h", s, dut_vec(), exp_vec);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int guard;
    guard = 0;
    while (phase != 0 && guard < 4) begin
      step_pins(dir == 1'b0);
      repeat (100) cyc();
      guard++;
    end
    dir = 0;
    repeat (100) cyc();
    a = 1; b = 1; phase = 2;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++; $display("FAIL illegal_model got %h exp %h", dut_vec(), exp_vec);
      end
      if (k == SYNC_STAGES + 2 || k == 60) begin
        checks++;
        if (err_o !== 1'b1) begin
          errors++; $display("FAIL illegal_err got %b exp 1", err_o);
        end
      end
      if (k == 60) begin
        checks++;
        if (edge_o !== (src_o ? 2'(E_A_UP) : 2'(E_B_UP))) begin
          errors++; $display("FAIL illegal_last got edge %0d src %b", edge_o, src_o);
        end
      end
    end
    reset = 1'b0; a = 0; b = 0; phase = 0; dir = 0;
    model_reset();
    cyc();
    checks++;
    if (err_o !== 1'b0 || dut_vec() !== '0) begin
      errors++; $display("FAIL illegal_clear got %h err %b exp 0", dut_vec(), err_o);
    end
    reset = 1'b1;
    repeat (5) cyc();
  endtask

  initial begin
    reset = 1'b0; a = 0; b = 0; dir = 0;
    @(negedge clk_fast);
    test_reset();
    test_forward();
    test_decel();
    test_saturation();
    test_reversal();
    test_random();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
